// File: rtl/node_if_if.sv
// Signal bundle between a node_interface, its PE and its router port 0.
// The node takes the slave view; the PE/network side takes the master view.
interface node_if #(
  parameter int PKT_W = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int OW = $clog2(DEPTH) + 1;

  logic [PKT_W-1:0] pe_data;
  logic             pe_data_val;
  logic             pe_ready;
  logic             inject_en;
  logic [PKT_W-1:0] net_data;
  logic             net_data_val;
  logic             net_en;
  logic [PKT_W-1:0] ej_data;
  logic             ej_data_val;
  logic [PKT_W-1:0] rx_data;
  logic             rx_val;
  logic [OW-1:0]    occupancy;
  logic [CNT_W-1:0] tx_count;
  logic [CNT_W-1:0] rx_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output pe_data, pe_data_val, inject_en, net_en, ej_data, ej_data_val,
    input  pe_ready, net_data, net_data_val, rx_data, rx_val, occupancy,
           tx_count, rx_count, err_count
  );

  modport slave (
    input  pe_data, pe_data_val, inject_en, net_en, ej_data, ej_data_val,
    output pe_ready, net_data, net_data_val, rx_data, rx_val, occupancy,
           tx_count, rx_count, err_count
  );
endinterface

// File: rtl/node_interface.sv
// Mesh node network interface: inject FIFO toward router port 0, registered
// eject path with destination check, and saturating TX/RX/error statistics.
module node_interface #(
  parameter int NODE_ID  = 0,
  parameter int PKT_W    = 32,
  parameter int DEST_LSB = 0,
  parameter int DEST_W   = 4,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16
) (
  input  logic  clk,
  input  logic  reset,
  node_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0]     FULL_OCC = OW'(DEPTH);
  localparam logic [DEST_W-1:0] MY_ID    = DEST_W'(NODE_ID);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic en);
    if (en && (c != '1)) return c + CNT_W'(1);
    return c;
  endfunction

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [OW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [PKT_W-1:0] rx_data_q;
  logic             rx_val_q;
  logic             full, empty, push, pop, misroute;

  // Pointers carry an extra wrap bit so full and empty differ with equal indices.
  always_comb begin
    occ       = wr_ptr_q - rd_ptr_q;
    full      = (occ == FULL_OCC);
    empty     = (occ == '0);
    push      = bus.pe_data_val & ~full;
    pop       = ~empty & bus.inject_en & bus.net_en;
    misroute  = (bus.ej_data[DEST_LSB +: DEST_W] != MY_ID);
    wr_ptr_d  = push ? wr_ptr_q + OW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + OW'(1) : rd_ptr_q;
    tx_cnt_d  = sat_inc(tx_cnt_q, pop);
    rx_cnt_d  = sat_inc(rx_cnt_q, bus.ej_data_val);
    err_cnt_d = sat_inc(err_cnt_q, bus.ej_data_val & misroute);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.pe_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
      rx_data_q <= '0;
      rx_val_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
      rx_data_q <= bus.ej_data;
      rx_val_q  <= bus.ej_data_val;
    end
  end

  // Head is masked while empty so stale storage never leaks onto the network.
  assign bus.pe_ready     = ~full;
  assign bus.net_data     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.net_data_val = ~empty & bus.inject_en;
  assign bus.occupancy    = occ;
  assign bus.tx_count     = tx_cnt_q;
  assign bus.rx_count     = rx_cnt_q;
  assign bus.err_count    = err_cnt_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_val       = rx_val_q;
endmodule

// File: tb/tb_node_interface.sv
// Bench for node_interface: queue-based reference model compared every cycle,
// plus directed literal checks for each scenario.
module tb_node_interface;
  localparam int NID = 5;
  localparam int DEP = 4;
  localparam int CW  = 5;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  node_if #(.PKT_W(32), .DEPTH(DEP), .CNT_W(CW)) bus ();

  node_interface #(
    .NODE_ID(NID), .PKT_W(32), .DEST_LSB(0), .DEST_W(4), .DEPTH(DEP), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a packet queue plus plain saturating integer counters.
  logic [31:0] mq[$];
  int          m_tx = 0, m_rx = 0, m_err = 0;
  logic        m_rxv = 1'b0;
  logic [31:0] m_rxd = '0;
  bit          m_push, m_pop;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_tx = 0; m_rx = 0; m_err = 0;
      m_rxv = 1'b0; m_rxd = '0;
    end else begin
      m_pop  = (mq.size() > 0) && bus.inject_en && bus.net_en;
      m_push = bus.pe_data_val && (mq.size() < DEP);
      if (m_pop) begin
        void'(mq.pop_front());
        if (m_tx < SAT) m_tx++;
      end
      if (m_push) mq.push_back(bus.pe_data);
      m_rxv = bus.ej_data_val;
      m_rxd = bus.ej_data;
      if (bus.ej_data_val) begin
        if (m_rx < SAT) m_rx++;
        if (bus.ej_data[3:0] != 4'(NID) && m_err < SAT) m_err++;
      end
    end
  end

  always @(negedge clk) begin
    chk("pe_ready",  64'(bus.pe_ready),     64'(mq.size() < DEP));
    chk("net_val",   64'(bus.net_data_val), 64'((mq.size() > 0) && bus.inject_en));
    chk("net_data",  64'(bus.net_data),     (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
    chk("occupancy", 64'(bus.occupancy),    64'(mq.size()));
    chk("tx_count",  64'(bus.tx_count),     64'(m_tx));
    chk("rx_count",  64'(bus.rx_count),     64'(m_rx));
    chk("err_count", 64'(bus.err_count),    64'(m_err));
    chk("rx_val",    64'(bus.rx_val),       64'(m_rxv));
    chk("rx_data",   64'(bus.rx_data),      64'(m_rxd));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.pe_data = '0; bus.pe_data_val = 1'b0; bus.inject_en = 1'b1;
    bus.net_en = 1'b0; bus.ej_data = '0; bus.ej_data_val = 1'b0;
    step(); step();
    chk("rst_pe_ready", 64'(bus.pe_ready), 64'd1);
    chk("rst_occ",      64'(bus.occupancy), 64'd0);
    chk("rst_net_val",  64'(bus.net_data_val), 64'd0);
    chk("rst_tx",       64'(bus.tx_count), 64'd0);
    reset = 1'b0;
    step();

    // 1: single packet, network ready
    bus.pe_data = 32'h1234_0005; bus.pe_data_val = 1'b1; bus.net_en = 1'b1;
    step();
    bus.pe_data_val = 1'b0;
    chk("t1_val",  64'(bus.net_data_val), 64'd1);
    chk("t1_data", 64'(bus.net_data), 64'h1234_0005);
    chk("t1_occ",  64'(bus.occupancy), 64'd1);
    step();
    chk("t1_tx",   64'(bus.tx_count), 64'd1);
    chk("t1_occ0", 64'(bus.occupancy), 64'd0);

    // 2: fill to DEPTH with network stalled, fifth held by PE
    bus.net_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.pe_data = 32'hB000_0010 + 32'(i); bus.pe_data_val = 1'b1;
      step();
    end
    chk("t2_occ4",  64'(bus.occupancy), 64'd4);
    chk("t2_full",  64'(bus.pe_ready), 64'd0);
    bus.pe_data = 32'hB000_0015;
    step();
    chk("t2_hold",  64'(bus.occupancy), 64'd4);
    bus.net_en = 1'b1;
    step();
    chk("t2_rdy",   64'(bus.pe_ready), 64'd1);
    chk("t2_head2", 64'(bus.net_data), 64'hB000_0012);
    step();
    bus.pe_data_val = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      chk("t2_order", 64'(bus.net_data), 64'hB000_0010 + 64'(i));
      step();
    end
    chk("t2_empty", 64'(bus.occupancy), 64'd0);

    // 3: steady push+pop at occupancy 2 across pointer wrap
    bus.net_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.pe_data = 32'hC000_0000 + 32'(i); bus.pe_data_val = 1'b1;
      step();
    end
    for (int k = 0; k < 12; k++) begin
      bus.pe_data = 32'hC000_0002 + 32'(k); bus.pe_data_val = 1'b1; bus.net_en = 1'b1;
      #1;
      chk("t3_head", 64'(bus.net_data), 64'hC000_0000 + 64'(k));
      chk("t3_occ",  64'(bus.occupancy), 64'd2);
      step();
    end
    bus.pe_data_val = 1'b0;
    step(); step();
    chk("t3_empty", 64'(bus.occupancy), 64'd0);

    // 4: injection paused then resumed
    bus.net_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.pe_data = 32'hD000_0000 + 32'(i); bus.pe_data_val = 1'b1;
      step();
    end
    bus.pe_data_val = 1'b0; bus.inject_en = 1'b0; bus.net_en = 1'b1;
    step(); step();
    chk("t4_paused", 64'(bus.net_data_val), 64'd0);
    chk("t4_occ3",   64'(bus.occupancy), 64'd3);
    bus.inject_en = 1'b1;
    #1;
    chk("t4_resume", 64'(bus.net_data_val), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_drain", 64'(bus.occupancy), 64'(2 - i));
    end
    chk("t4_tx", 64'(bus.tx_count), 64'd23);

    // 5: eject good and misrouted packets, then saturate counters
    bus.ej_data = 32'hE000_0005; bus.ej_data_val = 1'b1;
    step();
    chk("t5_rxv",  64'(bus.rx_val), 64'd1);
    chk("t5_rxd",  64'(bus.rx_data), 64'hE000_0005);
    chk("t5_rx1",  64'(bus.rx_count), 64'd1);
    chk("t5_err0", 64'(bus.err_count), 64'd0);
    bus.ej_data = 32'hE000_0006;
    step();
    chk("t5_rx2",  64'(bus.rx_count), 64'd2);
    chk("t5_err1", 64'(bus.err_count), 64'd1);
    bus.ej_data_val = 1'b0;
    step();
    chk("t5_pulse", 64'(bus.rx_val), 64'd0);
    bus.ej_data_val = 1'b1;
    for (int i = 0; i < 31; i++) step();
    chk("t5_rxsat",  64'(bus.rx_count), 64'd31);
    chk("t5_errsat", 64'(bus.err_count), 64'd31);
    step(); step();
    chk("t5_rxhold",  64'(bus.rx_count), 64'd31);
    chk("t5_errhold", 64'(bus.err_count), 64'd31);
    bus.ej_data_val = 1'b0;
    step();

    // 6: asynchronous reset in the middle of a drain
    bus.net_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.pe_data = 32'hF000_0000 + 32'(i); bus.pe_data_val = 1'b1;
      step();
    end
    bus.pe_data_val = 1'b0; bus.net_en = 1'b1;
    #1;
    chk("t6_pre_occ", 64'(bus.occupancy), 64'd3);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_val",  64'(bus.net_data_val), 64'd0);
    chk("t6_occ",  64'(bus.occupancy), 64'd0);
    chk("t6_tx",   64'(bus.tx_count), 64'd0);
    chk("t6_rx",   64'(bus.rx_count), 64'd0);
    chk("t6_err",  64'(bus.err_count), 64'd0);
    chk("t6_rdy",  64'(bus.pe_ready), 64'd1);
    step();
    reset = 1'b0; bus.net_en = 1'b0;
    bus.pe_data = 32'hA5A5_0003; bus.pe_data_val = 1'b1;
    step();
    bus.pe_data_val = 1'b0;
    chk("t6_post_val",  64'(bus.net_data_val), 64'd1);
    chk("t6_post_data", 64'(bus.net_data), 64'hA5A5_0003);
    chk("t6_post_occ",  64'(bus.occupancy), 64'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
